ddr_test_engine: RTL and testbench

DDR_TEST_ENGINE -- requirements
Module: ddr_test_engine

---
 rtl/ddr_test_engine_pkg.sv | 19 +
 rtl/ddr_test_engine_if.sv | 49 ++++
 rtl/ddr_pattern_gen.sv | 13 +
 rtl/ddr_test_engine.sv | 206 ++++++++++++++++++++
 tb/tb_ddr_test_engine.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_test_engine_pkg.sv
// Constants and FSM state encoding shared by the DDR test engine files.
package ddr_test_engine_pkg;

    localparam int unsigned BEAT_BYTES  = 64;
    localparam int unsigned BURST_BEATS = 64;
    localparam int unsigned BURST_BYTES = BEAT_BYTES * BURST_BEATS;
    localparam int unsigned BEAT_BITS   = BEAT_BYTES * 8;
    localparam logic [7:0]  AXI_LEN     = 8'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        R_ADDR,
        R_DATA
    } state_e;

endpackage

// File: rtl/ddr_test_engine_if.sv
// AXI4 write/read channel bundle between the test engine (master) and memory (slave).
interface ddr_test_engine_if #(
    parameter int unsigned AW = 34
);
    logic [AW-1:0]  M_AXI_AWADDR;
    logic [7:0]     M_AXI_AWLEN;
    logic           M_AXI_AWVALID;
    logic           M_AXI_AWREADY;
    logic [511:0]   M_AXI_WDATA;
    logic           M_AXI_WLAST;
    logic           M_AXI_WVALID;
    logic           M_AXI_WREADY;
    logic           M_AXI_BVALID;
    logic           M_AXI_BREADY;
    logic [AW-1:0]  M_AXI_ARADDR;
    logic [7:0]     M_AXI_ARLEN;
    logic           M_AXI_ARVALID;
    logic           M_AXI_ARREADY;
    logic [511:0]   M_AXI_RDATA;
    logic           M_AXI_RVALID;
    logic           M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/ddr_pattern_gen.sv
// Address-derived test pattern: 32-bit lane i of a beat at byte address A is A + 4*i (mod 2^32).
module ddr_pattern_gen
    import ddr_test_engine_pkg::*;
(
    input  logic [31:0]          addr,
    output logic [BEAT_BITS-1:0] beat
);

    for (genvar i = 0; i < BEAT_BYTES / 4; i++) begin : g_lane
        assign beat[32*i +: 32] = addr + 32'(4 * i);
    end

endmodule

// File: rtl/ddr_test_engine.sv
// AXI4 DDR region fill/verify engine, one 4 KB burst outstanding at a time.
// Define PERF_COUNTERS_EN to build the perf_cycles operation timer; otherwise it reads 0.
module ddr_test_engine
    import ddr_test_engine_pkg::*;
#(
    parameter int unsigned   AW           = 34,
    parameter logic [AW-1:0] BASE_ADDR    = '0,
    parameter int unsigned   REGION_BYTES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_write,
    input  logic              start_read,
    output logic              busy,
    output logic [31:0]       mismatch_count,
    output logic [31:0]       perf_cycles,
    ddr_test_engine_if.master axi
);

    localparam int unsigned NUM_BURSTS = REGION_BYTES / BURST_BYTES;
    localparam logic [5:0]  LAST_BEAT  = 6'(BURST_BEATS - 1);
    localparam logic [31:0] LAST_BURST = 32'(NUM_BURSTS - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        burst_addr_q, burst_addr_d;
    logic [31:0]          burst_idx_q, burst_idx_d;
    logic [31:0]          beat_addr_q, beat_addr_d;
    logic [5:0]           beat_cnt_q, beat_cnt_d;
    logic [31:0]          mismatch_q, mismatch_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 wlast_q, wlast_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 busy_q, busy_d;
    logic [BEAT_BITS-1:0] beat_pattern;
    logic                 last_beat;
    logic                 last_burst;

    // One generator serves both paths: only one operation runs at a time.
    ddr_pattern_gen u_pattern (
        .addr (beat_addr_q),
        .beat (beat_pattern)
    );

    assign last_beat  = (beat_cnt_q == LAST_BEAT);
    assign last_burst = (burst_idx_q == LAST_BURST);

    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        burst_idx_d  = burst_idx_q;
        beat_addr_d  = beat_addr_q;
        beat_cnt_d   = beat_cnt_q;
        mismatch_d   = mismatch_q;
        case (state_q)
            IDLE: begin
                if (start_write) begin
                    state_d      = W_ADDR;
                    burst_addr_d = BASE_ADDR;
                    burst_idx_d  = '0;
                end else if (start_read) begin
                    state_d      = R_ADDR;
                    burst_addr_d = BASE_ADDR;
                    burst_idx_d  = '0;
                    mismatch_d   = '0;
                end
            end
            W_ADDR: begin
                if (awvalid_q && axi.M_AXI_AWREADY) begin
                    state_d     = W_DATA;
                    beat_addr_d = burst_addr_q[31:0];
                    beat_cnt_d  = '0;
                end
            end
            W_DATA: begin
                if (wvalid_q && axi.M_AXI_WREADY) begin
                    beat_addr_d = beat_addr_q + 32'(BEAT_BYTES);
                    beat_cnt_d  = beat_cnt_q + 6'd1;
                    if (last_beat) begin
                        state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready_q && axi.M_AXI_BVALID) begin
                    if (last_burst) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = W_ADDR;
                        burst_addr_d = burst_addr_q + AW'(BURST_BYTES);
                        burst_idx_d  = burst_idx_q + 32'd1;
                    end
                end
            end
            R_ADDR: begin
                if (arvalid_q && axi.M_AXI_ARREADY) begin
                    state_d     = R_DATA;
                    beat_addr_d = burst_addr_q[31:0];
                    beat_cnt_d  = '0;
                end
            end
            R_DATA: begin
                // Bursts end on the 64th counted beat; RLAST is deliberately not trusted.
                if (rready_q && axi.M_AXI_RVALID) begin
                    if ((axi.M_AXI_RDATA != beat_pattern) && (mismatch_q != '1)) begin
                        mismatch_d = mismatch_q + 32'd1;
                    end
                    beat_addr_d = beat_addr_q + 32'(BEAT_BYTES);
                    beat_cnt_d  = beat_cnt_q + 6'd1;
                    if (last_beat) begin
                        if (last_burst) begin
                            state_d = IDLE;
                        end else begin
                            state_d      = R_ADDR;
                            burst_addr_d = burst_addr_q + AW'(BURST_BYTES);
                            burst_idx_d  = burst_idx_q + 32'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        awvalid_d = (state_d == W_ADDR);
        wvalid_d  = (state_d == W_DATA);
        wlast_d   = (state_d == W_DATA) && (beat_cnt_d == LAST_BEAT);
        bready_d  = (state_d == W_RESP);
        arvalid_d = (state_d == R_ADDR);
        rready_d  = (state_d == R_DATA);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_addr_q <= BASE_ADDR;
            burst_idx_q  <= '0;
            beat_addr_q  <= '0;
            beat_cnt_q   <= '0;
            mismatch_q   <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            burst_idx_q  <= burst_idx_d;
            beat_addr_q  <= beat_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            mismatch_q   <= mismatch_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            wlast_q      <= wlast_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == IDLE) && (start_write || start_read)) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

    assign axi.M_AXI_AWADDR  = burst_addr_q;
    assign axi.M_AXI_AWLEN   = AXI_LEN;
    assign axi.M_AXI_AWVALID = awvalid_q;
    assign axi.M_AXI_WDATA   = beat_pattern;
    assign axi.M_AXI_WLAST   = wlast_q;
    assign axi.M_AXI_WVALID  = wvalid_q;
    assign axi.M_AXI_BREADY  = bready_q;
    assign axi.M_AXI_ARADDR  = burst_addr_q;
    assign axi.M_AXI_ARLEN   = AXI_LEN;
    assign axi.M_AXI_ARVALID = arvalid_q;
    assign axi.M_AXI_RREADY  = rready_q;
    assign busy              = busy_q;
    assign mismatch_count    = mismatch_q;

endmodule

// File: tb/tb_ddr_test_engine.sv
// Directed bench for ddr_test_engine over an 8 KB region with a reactive AXI memory model.
module tb_ddr_test_engine;

    localparam int unsigned   AW   = 34;
    localparam logic [AW-1:0] BASE = '0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_write = 1'b0;
    logic        start_read = 1'b0;
    logic        busy;
    logic [31:0] mismatch_count;
    logic [31:0] perf_cycles;

    int errors = 0;
    int checks = 0;

    ddr_test_engine_if #(.AW(AW)) axi ();

    ddr_test_engine #(.AW(AW), .BASE_ADDR(BASE), .REGION_BYTES(8192)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_write    (start_write),
        .start_read     (start_read),
        .busy           (busy),
        .mismatch_count (mismatch_count),
        .perf_cycles    (perf_cycles),
        .axi            (axi)
    );

    always #5 clk = ~clk;

    logic [511:0]  mem [0:127];
    logic [AW-1:0] aw_addrs[$];
    logic [AW-1:0] ar_addrs[$];
    logic [AW-1:0] w_addr, r_addr;
    logic [511:0]  stall_data;
    logic [31:0]   first_lane1;
    logic          stalled_prev;
    bit            wready_toggle = 0;
    bit            corrupt_en = 0;
    int w_beats, r_beats, b_count, wlast_count, wlast_errs, wdata_errs, len_errs;
    int stall_errs, stall_count, busy_cycles, b_pending, r_remaining, beat_in_burst;

    function automatic logic [511:0] tb_pattern(input logic [31:0] a);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = a + 32'(4 * i);
        return r;
    endfunction

    // Memory read path; optionally flips bit 0 of the beat at 0x1040.
    function automatic logic [511:0] mem_read(input logic [AW-1:0] a);
        logic [511:0] d;
        d = mem[a[12:6]];
        if (corrupt_en && (a == AW'(32'h1040))) d[0] = ~d[0];
        return d;
    endfunction

    task automatic clear_monitor();
        aw_addrs.delete(); ar_addrs.delete();
        w_beats = 0; r_beats = 0; b_count = 0; wlast_count = 0; wlast_errs = 0;
        wdata_errs = 0; len_errs = 0; stall_errs = 0; stall_count = 0; busy_cycles = 0;
        first_lane1 = '1;
    endtask

    // AXI slave: drives all its outputs at the falling edge, so handshakes decided here
    // complete at the following rising edge.
    initial begin
        axi.M_AXI_AWREADY = 0; axi.M_AXI_WREADY = 0; axi.M_AXI_BVALID = 0;
        axi.M_AXI_ARREADY = 0; axi.M_AXI_RVALID = 0; axi.M_AXI_RDATA = '0;
        b_pending = 0; r_remaining = 0; stalled_prev = 0; beat_in_burst = 0;
        w_addr = '0; r_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                axi.M_AXI_AWREADY = 0; axi.M_AXI_WREADY = 0; axi.M_AXI_BVALID = 0;
                axi.M_AXI_ARREADY = 0; axi.M_AXI_RVALID = 0; axi.M_AXI_RDATA = '0;
                b_pending = 0; r_remaining = 0; stalled_prev = 0;
            end else begin
                if (busy) busy_cycles++;
                axi.M_AXI_AWREADY = 1;
                axi.M_AXI_ARREADY = 1;
                axi.M_AXI_WREADY  = wready_toggle ? ~axi.M_AXI_WREADY : 1'b1;
                axi.M_AXI_BVALID  = (b_pending > 0);
                if (r_remaining > 0) begin
                    axi.M_AXI_RVALID = 1;
                    axi.M_AXI_RDATA  = mem_read(r_addr);
                end else begin
                    axi.M_AXI_RVALID = 0;
                end
                if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
                    aw_addrs.push_back(axi.M_AXI_AWADDR);
                    if (axi.M_AXI_AWLEN !== 8'd63) len_errs++;
                    w_addr = axi.M_AXI_AWADDR;
                    beat_in_burst = 0;
                end
                if (axi.M_AXI_WVALID && !axi.M_AXI_WREADY) begin
                    if (stalled_prev && (axi.M_AXI_WDATA !== stall_data)) stall_errs++;
                    stalled_prev = 1;
                    stall_data = axi.M_AXI_WDATA;
                    stall_count++;
                end else begin
                    stalled_prev = 0;
                end
                if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
                    if (axi.M_AXI_WDATA !== tb_pattern(w_addr[31:0])) wdata_errs++;
                    if (axi.M_AXI_WLAST !== (beat_in_burst == 63)) wlast_errs++;
                    if (w_beats == 0) first_lane1 = axi.M_AXI_WDATA[63:32];
                    mem[w_addr[12:6]] = axi.M_AXI_WDATA;
                    if (axi.M_AXI_WLAST) begin
                        wlast_count++;
                        b_pending++;
                    end
                    w_addr = w_addr + AW'(64);
                    beat_in_burst = (beat_in_burst == 63) ? 0 : beat_in_burst + 1;
                    w_beats++;
                end
                if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
                    b_count++;
                    b_pending--;
                end
                if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
                    r_remaining--;
                    r_addr = r_addr + AW'(64);
                    r_beats++;
                end
                if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                    ar_addrs.push_back(axi.M_AXI_ARADDR);
                    if (axi.M_AXI_ARLEN !== 8'd63) len_errs++;
                    r_addr = axi.M_AXI_ARADDR;
                    r_remaining = 64;
                end
            end
        end
    end

    task automatic pulse(input bit w, input bit r);
        @(negedge clk); #1;
        start_write = w; start_read = r;
        @(negedge clk); #1;
        start_write = 0; start_read = 0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < limit)) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n); end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        checks++; if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY} !== 5'b0) begin errors++; $display("[TB] FAIL rst_handshake: got %b required 00000", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}); end
        checks++; if (mismatch_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_mismatch: got %0h required 0", mismatch_count); end
        checks++; if (perf_cycles !== 32'd0) begin errors++; $display("[TB] FAIL rst_perf: got %0h required 0", perf_cycles); end
        checks++; if ((axi.M_AXI_AWADDR !== BASE) || (axi.M_AXI_ARADDR !== BASE)) begin errors++; $display("[TB] FAIL rst_addr: got aw=%0h ar=%0h required %0h", axi.M_AXI_AWADDR, axi.M_AXI_ARADDR, BASE); end
        reset = 0;
    endtask

    task automatic test_write_basic();
        int exp_perf;
        clear_monitor();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_before: got %b required 0", busy); end
        pulse(1, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy_after_start: got %b required 1", busy); end
        wait_idle("wr", 2000);
        checks++; if (b_count !== 2) begin errors++; $display("[TB] FAIL wr_b_at_idle: got %0d required 2", b_count); end
        checks++; if (aw_addrs.size() !== 2) begin errors++; $display("[TB] FAIL wr_aw_count: got %0d required 2", aw_addrs.size()); end
        if (aw_addrs.size() == 2) begin
            checks++; if (aw_addrs[0] !== AW'(32'h0)) begin errors++; $display("[TB] FAIL wr_aw0: got %0h required 0", aw_addrs[0]); end
            checks++; if (aw_addrs[1] !== AW'(32'h1000)) begin errors++; $display("[TB] FAIL wr_aw1: got %0h required 1000", aw_addrs[1]); end
        end
        checks++; if (w_beats !== 128) begin errors++; $display("[TB] FAIL wr_beats: got %0d required 128", w_beats); end
        checks++; if (first_lane1 !== 32'h4) begin errors++; $display("[TB] FAIL wr_beat0_lane1: got %0h required 4", first_lane1); end
        checks++; if (wdata_errs !== 0) begin errors++; $display("[TB] FAIL wr_pattern: got %0d bad beats required 0", wdata_errs); end
        checks++; if ((wlast_count !== 2) || (wlast_errs !== 0)) begin errors++; $display("[TB] FAIL wr_wlast: got count=%0d errs=%0d required 2/0", wlast_count, wlast_errs); end
        checks++; if (len_errs !== 0) begin errors++; $display("[TB] FAIL wr_awlen: got %0d bad lens required 0", len_errs); end
`ifdef PERF_COUNTERS_EN
        exp_perf = busy_cycles;
`else
        exp_perf = 0;
`endif
        checks++; if (perf_cycles !== 32'(exp_perf)) begin errors++; $display("[TB] FAIL wr_perf: got %0d required %0d", perf_cycles, exp_perf); end
    endtask

    task automatic test_read(input bit corrupt, input int exp_mismatch);
        clear_monitor();
        corrupt_en = corrupt;
        pulse(0, 1);
        wait_idle("rd", 2000);
        checks++; if (ar_addrs.size() !== 2) begin errors++; $display("[TB] FAIL rd_ar_count: got %0d required 2", ar_addrs.size()); end
        if (ar_addrs.size() == 2) begin
            checks++; if ((ar_addrs[0] !== AW'(32'h0)) || (ar_addrs[1] !== AW'(32'h1000))) begin errors++; $display("[TB] FAIL rd_ar_addr: got %0h,%0h required 0,1000", ar_addrs[0], ar_addrs[1]); end
        end
        checks++; if (r_beats !== 128) begin errors++; $display("[TB] FAIL rd_beats: got %0d required 128", r_beats); end
        checks++; if (aw_addrs.size() !== 0) begin errors++; $display("[TB] FAIL rd_no_aw: got %0d required 0", aw_addrs.size()); end
        checks++; if (mismatch_count !== 32'(exp_mismatch)) begin errors++; $display("[TB] FAIL rd_mismatch: got %0d required %0d", mismatch_count, exp_mismatch); end
        corrupt_en = 0;
    endtask

    task automatic test_start_conflicts();
        clear_monitor();
        pulse(1, 1);
        wait_idle("both", 2000);
        checks++; if ((aw_addrs.size() !== 2) || (ar_addrs.size() !== 0)) begin errors++; $display("[TB] FAIL both_write_only: got aw=%0d ar=%0d required 2/0", aw_addrs.size(), ar_addrs.size()); end
        checks++; if (mismatch_count !== 32'd1) begin errors++; $display("[TB] FAIL mismatch_kept_by_write: got %0d required 1", mismatch_count); end
        clear_monitor();
        pulse(1, 0);
        repeat (20) @(negedge clk);
        pulse(0, 1);
        wait_idle("midread", 2000);
        repeat (3) @(negedge clk);
        #1;
        checks++; if ((ar_addrs.size() !== 0) || (aw_addrs.size() !== 2) || (busy !== 1'b0)) begin errors++; $display("[TB] FAIL midwrite_read_ignored: got ar=%0d aw=%0d busy=%b required 0/2/0", ar_addrs.size(), aw_addrs.size(), busy); end
    endtask

    task automatic test_wready_toggle();
        clear_monitor();
        wready_toggle = 1;
        pulse(1, 0);
        wait_idle("toggle", 4000);
        wready_toggle = 0;
        checks++; if (stall_count === 0) begin errors++; $display("[TB] FAIL tog_stalls_seen: got %0d required >0", stall_count); end
        checks++; if (stall_errs !== 0) begin errors++; $display("[TB] FAIL tog_wdata_stable: got %0d changes required 0", stall_errs); end
        checks++; if (w_beats !== 128) begin errors++; $display("[TB] FAIL tog_beats: got %0d required 128", w_beats); end
        checks++; if ((wlast_count !== 2) || (wlast_errs !== 0)) begin errors++; $display("[TB] FAIL tog_wlast: got count=%0d errs=%0d required 2/0", wlast_count, wlast_errs); end
        checks++; if (wdata_errs !== 0) begin errors++; $display("[TB] FAIL tog_pattern: got %0d bad beats required 0", wdata_errs); end
    endtask

    task automatic test_reset_mid_write();
        int n;
        clear_monitor();
        pulse(1, 0);
        n = 0;
        while ((w_beats < 10) && (n < 500)) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk);
        #2;
        checks++; if ((axi.M_AXI_WVALID !== 1'b1) || (w_beats !== 10)) begin errors++; $display("[TB] FAIL rmw_in_wdata: got wvalid=%b beats=%0d required 1/10", axi.M_AXI_WVALID, w_beats); end
        reset = 1;
        #1;
        checks++; if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY, busy} !== 6'b0) begin errors++; $display("[TB] FAIL rmw_async_clear: got %b required 000000", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY, busy}); end
        checks++; if (axi.M_AXI_AWADDR !== BASE) begin errors++; $display("[TB] FAIL rmw_addr: got %0h required %0h", axi.M_AXI_AWADDR, BASE); end
        repeat (2) @(negedge clk);
        #1;
        reset = 0;
        clear_monitor();
        pulse(1, 0);
        wait_idle("rmw", 2000);
        checks++; if ((aw_addrs.size() !== 2) || (aw_addrs.size() > 0 && aw_addrs[0] !== BASE)) begin errors++; $display("[TB] FAIL rmw_restart: got aw_count=%0d required 2 starting at %0h", aw_addrs.size(), BASE); end
        checks++; if ((w_beats !== 128) || (wdata_errs !== 0)) begin errors++; $display("[TB] FAIL rmw_rewrite: got beats=%0d bad=%0d required 128/0", w_beats, wdata_errs); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read(0, 0);
        test_read(1, 1);
        test_start_conflicts();
        test_wready_toggle();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
